// File: rtl/sump_host_sequencer.sv
// SUMP host sequencer: assembles short/long commands from UART RX bytes, answers the ID
// query, and serialises kept lanes of captured words onto UART TX. Option: SUMP_RX_TIMEOUT_EN.
module sump_host_sequencer #(
    parameter int MDW = 32,
    parameter int TMO = 16384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 str_rxd_tvalid,
    input  logic [7:0]           str_rxd_tdata,
    output logic                 str_rxd_tready,
    output logic [7:0]           ctl_code,
    output logic [31:0]          ctl_data,
    output logic                 ctl_valid,
    input  logic                 mem_tvalid,
    input  logic [MDW-1:0]       mem_tdata,
    input  logic [MDW/8-1:0]     mem_tkeep,
    output logic                 mem_tready,
    output logic                 str_txd_tvalid,
    output logic [7:0]           str_txd_tdata,
    input  logic                 str_txd_tready
);
    localparam int LANES = MDW / 8;

    typedef enum logic {R_IDLE, R_ARG} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ID, T_MEM} tx_state_t;

    rx_state_t        r_rx_state, w_rx_next;
    tx_state_t        r_tx_state, w_tx_next;
    logic [7:0]       r_opcode;
    logic [23:0]      r_arg;
    logic [1:0]       r_arg_cnt;
    logic [7:0]       r_ctl_code;
    logic [31:0]      r_ctl_data;
    logic             r_ctl_valid;
    logic             r_id_pending;
    logic [1:0]       r_id_idx;
    logic [MDW-1:0]   r_word;
    logic [LANES-1:0] r_keep;

    logic             w_rx_hs;
    logic             w_timeout;
    logic             w_id_last_hs;
    logic             w_mem_hs;
    logic             w_tx_valid;
    logic [7:0]       w_tx_data;
    logic             w_mem_ready;
    logic [LANES-1:0] w_lane_low;
    logic [LANES-1:0] w_keep_rest;
    logic [7:0]       w_lane_byte;

    // RX is held off while an ID reply is queued so replies cannot stack up.
    assign str_rxd_tready = rst & ~r_id_pending;
    assign w_rx_hs        = str_rxd_tvalid & str_rxd_tready;

`ifdef SUMP_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst || w_rx_hs || r_rx_state != R_ARG) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_rx_state == R_ARG) && !w_rx_hs && (r_tmo_cnt == TMO_W'(TMO - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= R_IDLE;
            r_tx_state <= T_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE: if (w_rx_hs && str_rxd_tdata[7]) w_rx_next = R_ARG;
            R_ARG: begin
                if (w_rx_hs && r_arg_cnt == 2'd3) w_rx_next = R_IDLE;
                else if (w_timeout)               w_rx_next = R_IDLE;
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            r_opcode     <= '0;
            r_arg        <= '0;
            r_arg_cnt    <= '0;
            r_ctl_code   <= '0;
            r_ctl_data   <= '0;
            r_ctl_valid  <= 1'b0;
            r_id_pending <= 1'b0;
        end else begin
            r_ctl_valid <= 1'b0;
            if (w_id_last_hs) r_id_pending <= 1'b0;
            if (w_rx_hs) begin
                if (r_rx_state == R_IDLE) begin
                    if (!str_rxd_tdata[7]) begin
                        r_ctl_valid <= 1'b1;
                        r_ctl_code  <= str_rxd_tdata;
                        r_ctl_data  <= '0;
                        if (str_rxd_tdata == 8'h02) r_id_pending <= 1'b1;
                    end else begin
                        r_opcode  <= str_rxd_tdata;
                        r_arg_cnt <= '0;
                    end
                end else begin
                    r_arg_cnt <= r_arg_cnt + 1'b1;
                    case (r_arg_cnt)
                        2'd0: r_arg[7:0]   <= str_rxd_tdata;
                        2'd1: r_arg[15:8]  <= str_rxd_tdata;
                        2'd2: r_arg[23:16] <= str_rxd_tdata;
                        default: begin
                            r_ctl_valid <= 1'b1;
                            r_ctl_code  <= r_opcode;
                            r_ctl_data  <= {str_rxd_tdata, r_arg};
                        end
                    endcase
                end
            end
        end
    end

    assign ctl_valid = r_ctl_valid;
    assign ctl_code  = r_ctl_code;
    assign ctl_data  = r_ctl_data;

    // Lanes drain lowest-first: isolate the lowest set keep bit each cycle.
    assign w_lane_low  = r_keep & (~r_keep + 1'b1);
    assign w_keep_rest = r_keep & ~w_lane_low;

    always_comb begin
        w_lane_byte = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_low[i]) w_lane_byte = r_word[8*i +: 8];
        end
    end

    always_comb begin
        w_tx_next    = r_tx_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = '0;
        w_mem_ready  = 1'b0;
        w_id_last_hs = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                if (r_id_pending) begin
                    w_tx_next = T_ID;
                end else begin
                    w_mem_ready = rst;
                    if (mem_tvalid && rst) w_tx_next = T_MEM;
                end
            end
            T_ID: begin
                w_tx_valid = 1'b1;
                case (r_id_idx)
                    2'd0:    w_tx_data = 8'h31;
                    2'd1:    w_tx_data = 8'h41;
                    2'd2:    w_tx_data = 8'h4C;
                    default: w_tx_data = 8'h53;
                endcase
                if (str_txd_tready && r_id_idx == 2'd3) begin
                    w_id_last_hs = 1'b1;
                    w_tx_next    = T_IDLE;
                end
            end
            T_MEM: begin
                if (r_keep == '0) begin
                    w_tx_next = T_IDLE;
                end else begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = w_lane_byte;
                    if (str_txd_tready && w_keep_rest == '0) w_tx_next = T_IDLE;
                end
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    assign w_mem_hs       = mem_tvalid & w_mem_ready;
    assign mem_tready     = w_mem_ready;
    assign str_txd_tvalid = w_tx_valid;
    assign str_txd_tdata  = w_tx_data;

    always_ff @(posedge clk) begin
        // NOTE: the word buffer is a plain register, so resetting it is cheap and keeps it deterministic.
        if (!rst) begin
            r_id_idx <= '0;
            r_word   <= '0;
            r_keep   <= '0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    r_id_idx <= '0;
                    if (w_mem_hs) begin
                        r_word <= mem_tdata;
                        r_keep <= mem_tkeep;
                    end
                end
                T_ID:  if (str_txd_tready) r_id_idx <= r_id_idx + 1'b1;
                T_MEM: if (str_txd_tready && r_keep != '0) r_keep <= w_keep_rest;
                default: r_id_idx <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_sump_host_sequencer.sv
// Self-checking bench for sump_host_sequencer: command table, readback scoreboard,
// ID arbitration, RX timeout (both builds of SUMP_RX_TIMEOUT_EN) and reset abandonment.
module tb_sump_host_sequencer;
    localparam int MDW   = 32;
    localparam int LANES = MDW / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             str_rxd_tvalid = 1'b0;
    logic [7:0]       str_rxd_tdata = '0;
    logic             str_rxd_tready;
    logic [7:0]       ctl_code;
    logic [31:0]      ctl_data;
    logic             ctl_valid;
    logic             mem_tvalid = 1'b0;
    logic [MDW-1:0]   mem_tdata = '0;
    logic [LANES-1:0] mem_tkeep = '0;
    logic             mem_tready;
    logic             str_txd_tvalid;
    logic [7:0]       str_txd_tdata;
    logic             str_txd_tready = 1'b1;

    always #5 clk = ~clk;

    sump_host_sequencer #(.MDW(MDW), .TMO(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .str_rxd_tvalid (str_rxd_tvalid),
        .str_rxd_tdata  (str_rxd_tdata),
        .str_rxd_tready (str_rxd_tready),
        .ctl_code       (ctl_code),
        .ctl_data       (ctl_data),
        .ctl_valid      (ctl_valid),
        .mem_tvalid     (mem_tvalid),
        .mem_tdata      (mem_tdata),
        .mem_tkeep      (mem_tkeep),
        .mem_tready     (mem_tready),
        .str_txd_tvalid (str_txd_tvalid),
        .str_txd_tdata  (str_txd_tdata),
        .str_txd_tready (str_txd_tready)
    );

    typedef struct packed {
        logic [7:0]  code;
        logic [31:0] data;
    } ctl_t;

    typedef struct packed {
        logic [39:0] bytes;   // first byte sent in [7:0]
        logic [2:0]  n;
        logic [7:0]  code;
        logic [31:0] data;
    } cmd_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_words  = 0;
    ctl_t ctl_q[$];
    logic [7:0] tx_q[$];
    bit   id_watch = 1'b0;
    bit   id_done = 1'b0;
    bit   id_done_chk = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        else             n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        str_rxd_tvalid = 1'b1;
        str_rxd_tdata  = b;
        @(negedge clk);
        while (!str_rxd_tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!str_rxd_tready) check("rx_accept", str_rxd_tready, 1);
        @(posedge clk); #1;
        str_rxd_tvalid = 1'b0;
        str_rxd_tdata  = '0;
    endtask

    task automatic mem_send(input logic [31:0] d, input logic [3:0] k, input bit chk_blocked, input bit push);
        int waited = 0;
        if (push) begin
            for (int l = 0; l < LANES; l++) if (k[l]) tx_q.push_back(d[8*l +: 8]);
        end
        mem_tvalid = 1'b1;
        mem_tdata  = d;
        mem_tkeep  = k;
        if (chk_blocked) begin
            @(negedge clk);
            check("id_wins_mem_tready", mem_tready, 0);
        end
        @(negedge clk);
        while (!mem_tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_tready) check("mem_accept", mem_tready, 1);
        else             n_words++;
        @(posedge clk); #1;
        mem_tvalid = 1'b0;
    endtask

    task automatic drain_tx();
        int waited = 0;
        while (tx_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
    endtask

    // Output monitors: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        ctl_t       e;
        logic [7:0] b;
        if (rst && ctl_valid) begin
            if (ctl_q.size() == 0) begin
                n_checks++;
                $display("FAIL ctl_unexpected: got strobe code %h data %h, required none (t=%0t)",
                         ctl_code, ctl_data, $time);
            end else begin
                e = ctl_q.pop_front();
                check("ctl_code", ctl_code, e.code);
                check("ctl_data", ctl_data, e.data);
            end
        end
        if (rst && str_txd_tvalid && str_txd_tready) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte %h, required none (t=%0t)", str_txd_tdata, $time);
            end else begin
                b = tx_q.pop_front();
                check("tx_byte", str_txd_tdata, b);
            end
        end
        if (rst && prev_stall) begin
            check("tx_hold_valid", str_txd_tvalid, 1);
            check("tx_hold_data", str_txd_tdata, prev_data);
        end
        prev_stall = rst && str_txd_tvalid && !str_txd_tready;
        prev_data  = str_txd_tdata;
        if (id_done_chk) begin
            check("rx_ready_after_id", str_rxd_tready, 1);
            id_done_chk = 1'b0;
        end
        if (rst && id_watch && !id_done) begin
            check("rx_blocked_during_id", str_rxd_tready, 0);
            if (str_txd_tvalid && str_txd_tready && str_txd_tdata == 8'h53) begin
                id_done     = 1'b1;
                id_done_chk = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        cmd_t        cmds[5];
        logic [39:0] bv;

        cmds[0] = '{40'h00000000_01, 3'd1, 8'h01, 32'h0000_0000};
        cmds[1] = '{40'h44332211_C0, 3'd5, 8'hC0, 32'h4433_2211};
        cmds[2] = '{40'h00000000_7F, 3'd1, 8'h7F, 32'h0000_0000};
        cmds[3] = '{40'h5AA500FF_80, 3'd5, 8'h80, 32'h5AA5_00FF};
        cmds[4] = '{40'h00000000_13, 3'd1, 8'h13, 32'h0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl_valid", ctl_valid, 0);
        check("rst_ctl_code", ctl_code, 0);
        check("rst_ctl_data", ctl_data, 0);
        check("rst_mem_tready", mem_tready, 0);
        check("rst_txd_tvalid", str_txd_tvalid, 0);
        check("rst_txd_tdata", str_txd_tdata, 0);
        check("rst_rxd_tready", str_rxd_tready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Command table
        for (int i = 0; i < 5; i++) begin
            bv = cmds[i].bytes;
            for (int k = 0; k < 5; k++) begin
                if (k < int'(cmds[i].n)) begin
                    if (k == int'(cmds[i].n) - 1) ctl_q.push_back('{cmds[i].code, cmds[i].data});
                    send_byte(bv[8*k +: 8]);
                end
            end
            if (i == 0) begin
                @(negedge clk);
                check("short_latency_strobe", ctl_valid, 1);
                @(negedge clk);
                check("short_single_strobe", ctl_valid, 0);
                @(posedge clk); #1;
            end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ctl_hold_code", ctl_code, 8'h13);
        check("ctl_hold_data", ctl_data, 32'h0);
        @(posedge clk); #1;

        // Readback with lane skipping and an empty keep
        n_words = 0;
        mem_send(32'hDDCC_BBAA, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        check("rb_first_valid", str_txd_tvalid, 1);
        check("rb_first_byte", str_txd_tdata, 8'hAA);
        @(posedge clk); #1;
        mem_send(32'h4433_2211, 4'b0101, 1'b0, 1'b1);
        mem_send(32'h9988_7766, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("keep0_busy", mem_tready, 0);
        @(negedge clk);
        check("keep0_return", mem_tready, 1);
        @(posedge clk); #1;
        drain_tx();
        check("rb_words_consumed", n_words, 3);

        // ID query racing a pending word, with back-pressure
        fork
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk); #1;
                    str_txd_tready = (c % 3) != 0;
                end
                str_txd_tready = 1'b1;
            end
            begin
                ctl_q.push_back('{8'h02, 32'h0});
                tx_q.push_back(8'h31);
                tx_q.push_back(8'h41);
                tx_q.push_back(8'h4C);
                tx_q.push_back(8'h53);
                send_byte(8'h02);
                id_watch = 1'b1;
                mem_send(32'h8765_4321, 4'b1111, 1'b1, 1'b1);
                drain_tx();
            end
        join
        @(posedge clk); #1;
        check("id_reply_complete", id_done, 1);

        // Long command with a 100-cycle gap between argument bytes
        send_byte(8'h80);
        send_byte(8'h01);
        repeat (100) @(posedge clk);
        #1;
`ifdef SUMP_RX_TIMEOUT_EN
        ctl_q.push_back('{8'h05, 32'h0});
        send_byte(8'h05);
`else
        send_byte(8'h05);
        send_byte(8'h06);
        ctl_q.push_back('{8'h80, 32'h0706_0501});
        send_byte(8'h07);
`endif
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a word and a partial command
        send_byte(8'hC0);
        send_byte(8'h11);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        mem_send(32'hDDCC_BBAA, 4'b1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_txd_tvalid", str_txd_tvalid, 0);
        check("rst_mid_txd_tdata", str_txd_tdata, 0);
        check("rst_mid_rxd_tready", str_rxd_tready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ctl_q.push_back('{8'h05, 32'h0});
        send_byte(8'h05);
        repeat (5) @(posedge clk);
        #1;

        check("ctl_queue_empty", ctl_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
